gpr_sync_mp: RTL and testbench
==============================

Name: gpr_sync_mp

Overview:
- Parametrised general-purpose register file with one write port and NREAD synchronous read ports; successor to the current two-port GPR.
- Same write-source merge (ALU/MEM result vs. CSR read data), now selected explicitly.
- Adds a registered read path with write-to-read bypass, read-hold, asynchronous clear of all state and a read-valid strobe.
- Sits between decode (read addresses) and writeback (write port) in the core datapath.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, register address width; depth = 2**AW.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is an ordinary register.
- BYPASS, 1, 1 = a same-edge write is forwarded to the read ports; 0 = reads return the pre-write value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- gpr_we  input  1  write enable.
- gpr_wsel  input  1  write source select: 0 = gpr_di, 1 = csr_rdata.
- gpr_rd  input  AW  write address.
- gpr_di  input  XLEN  write data from ALU/MEM.
- csr_rdata  input  XLEN  write data from CSR.
- gpr_re  input  1  read enable; 0 holds all read outputs.
- gpr_ra  input  NREAD*AW  read addresses; port i = bits [i*AW +: AW].
- gpr_q  output  NREAD*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- gpr_qvalid  output  1  high for one cycle after each edge with gpr_re=1.

Behaviour:
- Write data: wdata = gpr_wsel ? csr_rdata : gpr_di.
- Write commit: at a rising edge with gpr_we=1, mem[gpr_rd] <= wdata.
  - If ZERO_REG=1 and gpr_rd=0, the write is dropped.
- Read, 1-cycle latency: at a rising edge with gpr_re=1, for each port i:
  - ZERO_REG=1 and ra_i=0 -> q_i <= 0.
  - Otherwise, BYPASS=1 and gpr_we=1 and gpr_rd=ra_i (write not dropped) -> q_i <= wdata.
  - Otherwise -> q_i <= mem[ra_i], the pre-edge contents.
- gpr_re=0: q_i holds its last value and gpr_qvalid <= 0. Writes still commit.
- gpr_qvalid <= gpr_re on every edge.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- Write port and read ports are independent. No stall, no back-pressure, no illegal address (full depth is decoded).
- Reset, asserted at any time:
  - Immediately clears all 2**AW registers, every q_i and gpr_qvalid to 0, without waiting for clk.
  - A write or read on the same edge that rst is sampled high is discarded.
- After rst deasserts, the first rising edge operates normally.
- Reset mid-operation loses all contents; reads of any register return 0 until it is written.
- Parameter checks (elaboration error): NREAD outside 1..4; AW < 1; XLEN < 1.
- Implementation: flop array (no SRAM/buffer macros) for single-edge timing. Synthesisable; no latches; no initial blocks for state.

Test Plan:
- Reset: assert rst mid-cycle with nonzero contents. Required: gpr_q = 0 and gpr_qvalid = 0 immediately. Then read r1..r31 -> all 0x00000000.
- Write/read basic: write r5 = 0x1234_5678 (wsel=0), next cycle read r5 on port 0 and port 1. Required: both = 0x12345678 one edge after gpr_re, with gpr_qvalid=1 for exactly one cycle.
- CSR source and zero register: write r0 = 0xFFFF_FFFF with wsel=1, csr_rdata=0xFFFFFFFF. Read r0 -> 0. Write r7 from CSR = 0xDEAD_BEEF -> r7 reads 0xDEADBEEF. Repeat with ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
- Bypass: r9 = 0xAAAA_0000, then on the same edge write r9 = 0x5555_1111 and read r9. Required: BYPASS=1 gives 0x55551111; BYPASS=0 gives 0xAAAA0000, then 0x55551111 on the next read.
- Hold: read r3 = 0x3, then drop gpr_re and write r3 = 0x4. Required: gpr_q holds 0x3 and gpr_qvalid=0. Re-assert gpr_re -> 0x4.
- Parametrisation: NREAD=4, XLEN=64, AW=4, four different addresses read in one cycle. Required: each port returns its own 64-bit value; simultaneous identical addresses return identical data.

Source files
------------

// File: rtl/gpr_sync_mp.sv
// gpr_sync_mp: flop-based register file with one write port and NREAD
// registered read ports. Each read port can forward a write made on the same
// edge, holds its output while reads are disabled, and is cleared
// asynchronously with the rest of the state.

// One registered read port. Evaluates zero-register, bypass and array lookup
// against the pre-edge array contents.
module gpr_rport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            re,
  input  logic [AW-1:0]                   ra,
  input  logic [(1<<AW)-1:0][XLEN-1:0]    mem,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  input  logic [XLEN-1:0]                 wr_data,
  output logic [XLEN-1:0]                 q
);

  logic [XLEN-1:0] q_nxt;

  // read-data select: hard zero, forwarded write, or stored value
  always_comb begin
    q_nxt = mem[ra];
    if ((ZERO_REG != 0) && (ra == '0))
      q_nxt = '0;
    else if ((BYPASS != 0) && wr_en && (wr_addr == ra))
      q_nxt = wr_data;
  end

  // output register; holds while re is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (re) q <= q_nxt;
  end

endmodule

// Top: write-source merge, register array and the read-port array.
module gpr_sync_mp #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gpr_we,
  input  logic                    gpr_wsel,
  input  logic [AW-1:0]           gpr_rd,
  input  logic [XLEN-1:0]         gpr_di,
  input  logic [XLEN-1:0]         csr_rdata,
  input  logic                    gpr_re,
  input  logic [NREAD*AW-1:0]     gpr_ra,
  output logic [NREAD*XLEN-1:0]   gpr_q,
  output logic                    gpr_qvalid
);

  localparam int DEPTH = 1 << AW;

  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $error("gpr_sync_mp: NREAD must be in 1..4");
  end
  if (AW < 1) begin : g_bad_aw
    $error("gpr_sync_mp: AW must be >= 1");
  end
  if (XLEN < 1) begin : g_bad_xlen
    $error("gpr_sync_mp: XLEN must be >= 1");
  end

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_req_t;

  wr_req_t                     wr;
  logic [DEPTH-1:0][XLEN-1:0]  mem;

  // write request: source merge, and drop writes to a hardwired-zero r0
  always_comb begin
    wr.data = gpr_wsel ? csr_rdata : gpr_di;
    wr.addr = gpr_rd;
    wr.en   = gpr_we && !((ZERO_REG != 0) && (gpr_rd == '0));
  end

  // register array; reset wipes every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mem <= '0;
    else if (wr.en) mem[wr.addr] <= wr.data;
  end

  // read-valid strobe follows read enable by one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gpr_qvalid <= 1'b0;
    else     gpr_qvalid <= gpr_re;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    gpr_rport #(
      .XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rport (
      .clk    (clk),
      .rst    (rst),
      .re     (gpr_re),
      .ra     (gpr_ra[i*AW +: AW]),
      .mem    (mem),
      .wr_en  (wr.en),
      .wr_addr(wr.addr),
      .wr_data(wr.data),
      .q      (gpr_q[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_gpr_sync_mp.sv
// Bench for gpr_sync_mp: three instances (default, ZERO_REG=0/BYPASS=0 sharing
// the default's inputs, and a 4-port 64-bit 16-entry variant), each tracked
// by an array-based reference model.
module tb_gpr_sync_mp;

  logic        clk = 1'b0;
  logic        rst;
  // shared stimulus for dut0 / dut1
  logic        we, wsel, re;
  logic [4:0]  rd;
  logic [31:0] di, csr;
  logic [9:0]  ra;
  logic [63:0] q0, q1;
  logic        qv0, qv1;
  // stimulus for dut2
  logic        we2, wsel2, re2;
  logic [3:0]  rd2;
  logic [63:0] di2, csr2;
  logic [15:0] ra2;
  logic [255:0] q2;
  logic        qv2;

  int nchk = 0;
  int nerr = 0;

  // reference model state
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [63:0] m2 [16];
  logic [31:0] e0 [2];
  logic [31:0] e1 [2];
  logic [63:0] e2 [4];
  logic        eqv, eqv2;

  always #5 clk = ~clk;

  gpr_sync_mp dut0 (
    .clk(clk), .rst(rst), .gpr_we(we), .gpr_wsel(wsel), .gpr_rd(rd),
    .gpr_di(di), .csr_rdata(csr), .gpr_re(re), .gpr_ra(ra),
    .gpr_q(q0), .gpr_qvalid(qv0)
  );

  gpr_sync_mp #(.ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .gpr_we(we), .gpr_wsel(wsel), .gpr_rd(rd),
    .gpr_di(di), .csr_rdata(csr), .gpr_re(re), .gpr_ra(ra),
    .gpr_q(q1), .gpr_qvalid(qv1)
  );

  gpr_sync_mp #(.XLEN(64), .AW(4), .NREAD(4)) dut2 (
    .clk(clk), .rst(rst), .gpr_we(we2), .gpr_wsel(wsel2), .gpr_rd(rd2),
    .gpr_di(di2), .csr_rdata(csr2), .gpr_re(re2), .gpr_ra(ra2),
    .gpr_q(q2), .gpr_qvalid(qv2)
  );

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m0[i] = '0; m1[i] = '0; end
    for (int i = 0; i < 16; i++) m2[i] = '0;
    for (int i = 0; i < 2; i++) begin e0[i] = '0; e1[i] = '0; end
    for (int i = 0; i < 4; i++) e2[i] = '0;
    eqv = 1'b0; eqv2 = 1'b0;
  endtask

  // advance one clock edge and update the models, then settle 1 time unit
  task automatic tick();
    logic [31:0] wd;
    logic [63:0] wd2;
    logic [4:0]  a;
    logic [3:0]  b;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      wd = wsel ? csr : di;
      if (re)
        for (int p = 0; p < 2; p++) begin
          a = ra[p*5 +: 5];
          if (a == 0)                     e0[p] = '0;
          else if (we && rd == a)         e0[p] = wd;
          else                            e0[p] = m0[a];
          e1[p] = m1[a];
        end
      eqv = re;
      if (we) begin
        if (rd != 0) m0[rd] = wd;
        m1[rd] = wd;
      end
      wd2 = wsel2 ? csr2 : di2;
      if (re2)
        for (int p = 0; p < 4; p++) begin
          b = ra2[p*4 +: 4];
          if (b == 0)                     e2[p] = '0;
          else if (we2 && rd2 == b)       e2[p] = wd2;
          else                            e2[p] = m2[b];
        end
      eqv2 = re2;
      if (we2 && rd2 != 0) m2[rd2] = wd2;
    end
    #1;
  endtask

  task automatic wr0(input logic [4:0] r, input logic s, input logic [31:0] d, input logic [31:0] c);
    we = 1'b1; rd = r; wsel = s; di = d; csr = c;
  endtask

  task automatic test_reset();
    tick();
    nchk++; if (q0 !== '0 || q1 !== '0 || qv0 !== 1'b0) begin
      nerr++; $display("FAIL reset_init q0=%h q1=%h qv=%b want 0", q0, q1, qv0);
    end
    rst = 1'b0;
    wr0(5'd1, 1'b0, 32'h1111_1111, 32'h0); tick();
    wr0(5'd2, 1'b0, 32'h2222_2222, 32'h0); tick();
    we = 1'b0; re = 1'b1; ra = {5'd2, 5'd1}; tick();
    nchk++; if (q0 !== {32'h2222_2222, 32'h1111_1111}) begin
      nerr++; $display("FAIL pre_reset_read q0=%h want %h", q0, {32'h2222_2222, 32'h1111_1111});
    end
    // assert reset mid-cycle and look before any clock edge
    #3 rst = 1'b1;
    #1;
    model_clear();
    nchk++; if (q0 !== '0 || q1 !== '0 || qv0 !== 1'b0 || qv1 !== 1'b0) begin
      nerr++; $display("FAIL reset_async q0=%h q1=%h qv0=%b qv1=%b want 0", q0, q1, qv0, qv1);
    end
    // an edge while reset is held must not write or read
    wr0(5'd4, 1'b0, 32'hCAFE_F00D, 32'h0); re = 1'b1; ra = {5'd4, 5'd4};
    tick();
    nchk++; if (q0 !== '0 || qv0 !== 1'b0) begin
      nerr++; $display("FAIL reset_held q0=%h qv=%b want 0", q0, qv0);
    end
    #2 rst = 1'b0;
    we = 1'b0;
    for (int r = 1; r < 32; r += 2) begin
      ra = {((r == 31) ? 5'd31 : 5'(r + 1)), 5'(r)};
      tick();
      nchk++; if (q0 !== '0 || q1 !== '0) begin
        nerr++; $display("FAIL reset_clear r%0d q0=%h q1=%h want 0", r, q0, q1);
      end
    end
    re = 1'b0; tick();
  endtask

  task automatic test_basic();
    wr0(5'd5, 1'b0, 32'h1234_5678, 32'h9999_9999); tick();
    we = 1'b0; re = 1'b1; ra = {5'd5, 5'd5}; tick();
    nchk++; if (q0[31:0] !== 32'h1234_5678 || q0[63:32] !== 32'h1234_5678 || qv0 !== 1'b1) begin
      nerr++; $display("FAIL basic_read q0=%h qv=%b want 1234567812345678/1", q0, qv0);
    end
    re = 1'b0; tick();
    nchk++; if (qv0 !== 1'b0 || q0[31:0] !== 32'h1234_5678) begin
      nerr++; $display("FAIL basic_qvalid_drop qv=%b q=%h want 0/12345678", qv0, q0[31:0]);
    end
  endtask

  task automatic test_csr_zero();
    wr0(5'd0, 1'b1, 32'h0, 32'hFFFF_FFFF); tick();
    wr0(5'd7, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF); tick();
    we = 1'b0; re = 1'b1; ra = {5'd7, 5'd0}; tick();
    nchk++; if (q0 !== {32'hDEAD_BEEF, 32'h0}) begin
      nerr++; $display("FAIL csr_zero_z1 q0=%h want deadbeef00000000", q0);
    end
    nchk++; if (q1 !== {32'hDEAD_BEEF, 32'hFFFF_FFFF}) begin
      nerr++; $display("FAIL csr_zero_z0 q1=%h want deadbeefffffffff", q1);
    end
    re = 1'b0; tick();
  endtask

  task automatic test_bypass();
    wr0(5'd9, 1'b0, 32'hAAAA_0000, 32'h0); tick();
    wr0(5'd9, 1'b0, 32'h5555_1111, 32'h0); re = 1'b1; ra = {5'd9, 5'd9}; tick();
    nchk++; if (q0 !== {2{32'h5555_1111}}) begin
      nerr++; $display("FAIL bypass_on q0=%h want 5555111155551111", q0);
    end
    nchk++; if (q1 !== {2{32'hAAAA_0000}}) begin
      nerr++; $display("FAIL bypass_off q1=%h want aaaa0000aaaa0000", q1);
    end
    we = 1'b0; tick();
    nchk++; if (q1 !== {2{32'h5555_1111}}) begin
      nerr++; $display("FAIL bypass_off_next q1=%h want 5555111155551111", q1);
    end
    re = 1'b0; tick();
  endtask

  task automatic test_hold();
    wr0(5'd3, 1'b0, 32'h3, 32'h0); tick();
    we = 1'b0; re = 1'b1; ra = {5'd3, 5'd3}; tick();
    nchk++; if (q0[31:0] !== 32'h3) begin
      nerr++; $display("FAIL hold_first q=%h want 3", q0[31:0]);
    end
    re = 1'b0; wr0(5'd3, 1'b0, 32'h4, 32'h0); tick();
    we = 1'b0; tick();
    nchk++; if (q0 !== {2{32'h3}} || qv0 !== 1'b0 || q1 !== {2{32'h3}}) begin
      nerr++; $display("FAIL hold_keep q0=%h q1=%h qv=%b want 3/3/0", q0, q1, qv0);
    end
    re = 1'b1; tick();
    nchk++; if (q0 !== {2{32'h4}} || qv0 !== 1'b1) begin
      nerr++; $display("FAIL hold_release q0=%h qv=%b want 4/1", q0, qv0);
    end
    re = 1'b0; tick();
  endtask

  task automatic test_param();
    logic [63:0] v [4];
    logic [3:0]  adr [4];
    adr[0] = 4'd1; adr[1] = 4'd2; adr[2] = 4'd3; adr[3] = 4'd15;
    for (int i = 0; i < 4; i++) begin
      v[i] = {$urandom, $urandom};
      we2 = 1'b1; wsel2 = i[0]; rd2 = adr[i];
      di2 = i[0] ? 64'h0 : v[i]; csr2 = i[0] ? v[i] : 64'h0;
      tick();
    end
    we2 = 1'b0; re2 = 1'b1; ra2 = {adr[0], adr[2], adr[1], adr[3]};
    tick();
    nchk++; if (q2 !== {v[0], v[2], v[1], v[3]} || qv2 !== 1'b1) begin
      nerr++; $display("FAIL param_distinct q2=%h want %h", q2, {v[0], v[2], v[1], v[3]});
    end
    ra2 = {4{4'd2}}; tick();
    nchk++; if (q2 !== {4{v[1]}}) begin
      nerr++; $display("FAIL param_same q2=%h want %h", q2, {4{v[1]}});
    end
    ra2 = {4'd0, 4'd15, 4'd0, 4'd3}; tick();
    nchk++; if (q2 !== {64'h0, v[3], 64'h0, v[2]}) begin
      nerr++; $display("FAIL param_zero q2=%h want %h", q2, {64'h0, v[3], 64'h0, v[2]});
    end
    re2 = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom); wsel = 1'($urandom); re = ($urandom_range(0, 3) != 0);
      ra = 10'($urandom); di = $urandom; csr = $urandom;
      rd = ($urandom_range(0, 2) == 0) ? ra[4:0] : 5'($urandom);
      we2 = 1'($urandom); wsel2 = 1'($urandom); re2 = ($urandom_range(0, 3) != 0);
      ra2 = 16'($urandom); di2 = {$urandom, $urandom}; csr2 = {$urandom, $urandom};
      rd2 = ($urandom_range(0, 2) == 0) ? ra2[7:4] : 4'($urandom);
      tick();
      for (int p = 0; p < 2; p++) begin
        nchk++; if (q0[p*32 +: 32] !== e0[p]) begin
          nerr++; $display("FAIL rand_dut0 cyc%0d p%0d got %h want %h", n, p, q0[p*32 +: 32], e0[p]);
        end
        nchk++; if (q1[p*32 +: 32] !== e1[p]) begin
          nerr++; $display("FAIL rand_dut1 cyc%0d p%0d got %h want %h", n, p, q1[p*32 +: 32], e1[p]);
        end
      end
      for (int p = 0; p < 4; p++) begin
        nchk++; if (q2[p*64 +: 64] !== e2[p]) begin
          nerr++; $display("FAIL rand_dut2 cyc%0d p%0d got %h want %h", n, p, q2[p*64 +: 64], e2[p]);
        end
      end
      nchk++; if (qv0 !== eqv || qv1 !== eqv || qv2 !== eqv2) begin
        nerr++; $display("FAIL rand_qvalid cyc%0d got %b%b%b want %b%b%b", n, qv0, qv1, qv2, eqv, eqv, eqv2);
      end
    end
    we = 1'b0; re = 1'b0; we2 = 1'b0; re2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    we = 0; wsel = 0; re = 0; rd = '0; di = '0; csr = '0; ra = '0;
    we2 = 0; wsel2 = 0; re2 = 0; rd2 = '0; di2 = '0; csr2 = '0; ra2 = '0;
    model_clear();
    test_reset();
    test_basic();
    test_csr_zero();
    test_bypass();
    test_hold();
    test_param();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
